// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronised input, mid-bit sampling,
// optional parity, 1 or 2 checked stop bits, framing/parity/break reporting.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] LP_HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LP_BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LP_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LP_LAST_STOP = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_CLEANUP = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_low;
    logic                 r_stop_high;

    logic w_bit_end;
    logic w_half_end;
    logic w_data_xor;
    logic w_par_err;
    logic w_frame_err;
    logic w_break;

    assign w_bit_end  = (r_clk_cnt == LP_BIT_END);
    assign w_half_end = (r_clk_cnt == LP_HALF_END);

    // Evaluated at the final stop sample, where r_rx_s is that last stop bit.
    assign w_data_xor  = (^r_shift) ^ r_par_bit;
    assign w_par_err   = (PARITY == 1) ? ~w_data_xor :
                         (PARITY == 2) ?  w_data_xor : 1'b0;
    assign w_frame_err = r_stop_low | ~r_rx_s;
    // r_par_bit is forced to 0 at the end of DATA, so no-parity frames pass here.
    assign w_break     = (r_shift == '0) & ~r_par_bit & ~r_stop_high & ~r_rx_s;

    assign o_Busy = (r_state != ST_IDLE);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= ST_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_stop_low   <= 1'b0;
            r_stop_high  <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            r_rx_meta <= i_RX_Serial;
            r_rx_s    <= r_rx_meta;
            o_RX_DV   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_half_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == LP_LAST_DATA) begin
                            r_bit_idx   <= '0;
                            r_par_bit   <= 1'b0;
                            r_stop_low  <= 1'b0;
                            r_stop_high <= 1'b0;
                            r_state     <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == LP_LAST_STOP) begin
                            r_bit_idx    <= '0;
                            o_RX_DV      <= 1'b1;
                            o_RX_Byte    <= r_shift;
                            o_Parity_Err <= w_par_err;
                            o_Frame_Err  <= w_frame_err;
                            o_Break      <= w_break;
                            r_state      <= w_frame_err ? ST_CLEANUP : ST_IDLE;
                        end else begin
                            r_bit_idx   <= r_bit_idx + 1'b1;
                            r_stop_low  <= r_stop_low | ~r_rx_s;
                            r_stop_high <= r_stop_high | r_rx_s;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                // A low line after a bad frame must not be mistaken for a new start.
                ST_CLEANUP: begin
                    r_clk_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clocks per serial bit; legal range is 4 or more, even values only.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range is 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked: 1 or 2.
REQ-005 SHALL have port i_Clock  input  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_RX_Serial  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port o_RX_DV  output  1  one-cycle pulse: frame complete.
REQ-009 SHALL have port o_RX_Byte  output  DATA_BITS  received data, LSB first on the line.
REQ-010 SHALL have port o_Parity_Err  output  1  parity mismatch on the last frame.
REQ-011 SHALL have port o_Frame_Err  output  1  a stop bit sampled low on the last frame.
REQ-012 SHALL have port o_Break  output  1  last frame was all-zero including the stop bits.
REQ-013 SHALL have port o_Busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL pass i_RX_Serial through a 2-flop synchronizer; all decisions use the synchronized signal (rx_s).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP with a clock counter and a bit index.
REQ-016 IDLE: on rx_s == 0, SHALL go to START with the counter cleared.
REQ-017 START: after CLKS_PER_BIT/2 clocks (mid-bit), SHALL go to DATA if rx_s == 0; if rx_s == 1 it is a false start and SHALL return to IDLE with no output change.
REQ-018 DATA: SHALL sample rx_s every CLKS_PER_BIT clocks into bit index 0..DATA_BITS-1, LSB first.
REQ-019 After the last data bit, SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-020 PARITY: SHALL sample one bit; error = (XOR of data ^ sampled bit) != 1 for odd, != 0 for even.
REQ-021 STOP: SHALL sample STOP_BITS bits at CLKS_PER_BIT spacing; any low sample sets the frame error.
REQ-022 In the clock after the final stop sample, SHALL pulse o_RX_DV for exactly 1 cycle and update o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break in the same cycle.
REQ-023 o_RX_Byte and the error flags SHALL hold until the next o_RX_DV.
REQ-024 o_Break SHALL be set when all data bits, the parity bit (if any) and all stop samples are 0; o_Frame_Err SHALL also be 1 in that case.
REQ-025 With no frame error, SHALL enter IDLE directly after the DV cycle, so a start bit immediately following the stop bit is received (back-to-back frames).
REQ-026 With a frame error, SHALL enter CLEANUP and stay there until rx_s == 1, then go to IDLE; a held-low line yields exactly one DV.
REQ-027 End-to-end latency from the line edge to the first sample SHALL include the 2-cycle synchronizer delay; the sample point SHALL be mid-bit ±1 clock.
REQ-028 Counter and bit-index widths SHALL be $clog2-sized from the parameters; no wrap SHALL occur within a frame.

Reset
REQ-029 While i_Reset is high at a clock edge: state = IDLE, counters = 0, synchronizer flops = 1.
REQ-030 While i_Reset is high at a clock edge: o_RX_DV = 0, o_RX_Byte = 0, all error flags = 0, o_Busy = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no DV.
REQ-032 After reset, a line still low SHALL be treated as a start only once rx_s has actually gone low (synchronizer preset to 1).

Verification
REQ-033 Defaults (CLKS_PER_BIT=4, 8N1), byte 0x55 -> exactly one DV pulse, o_RX_Byte = 0x55, all error flags 0.
REQ-034 Defaults, "A" through "y" sent back-to-back with zero idle gap -> one DV per frame, each byte matches, no errors.
REQ-035 Line low for 1 clock only -> no DV, o_Busy returns to 0 within CLKS_PER_BIT/2 + 3 clocks.
REQ-036 PARITY=2, 0x41 sent with parity bit 1 -> DV, o_RX_Byte = 0x41, o_Parity_Err = 1; resend with parity bit 0 -> o_Parity_Err = 0.
REQ-037 STOP_BITS=2, second stop bit 0 -> o_Frame_Err = 1; line held low for 20 bit times -> exactly one DV with o_RX_Byte = 0x00 and o_Break = 1, and the next valid frame decodes normally.
REQ-038 DATA_BITS=7, reset pulsed at data bit 3 -> no DV; the following frame 0x2A is received correctly.
